iso_char_rx: RTL and testbench

ISO_CHAR_RX -- requirements
Module: iso_char_rx

---
 rtl/iso7816_pkg.sv | 21 ++
 rtl/iso_char_rx_if.sv | 25 ++
 rtl/etu_timer.sv | 28 ++
 rtl/iso_char_rx.sv | 150 +++++++++++++++
 tb/tb_iso_char_rx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/iso7816_pkg.sv
// Shared definitions for the ISO 7816 character receiver: state encoding,
// default ETU counter width and the bit-position helper for both conventions.
package iso7816_pkg;

   localparam int unsigned ETU_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      GUARD  = 3'd4,
      ERRSIG = 3'd5
   } rx_state_e;

   // Inverse convention sends MSB first, so received bit k lands at 7-k.
   function automatic logic [2:0] bit_pos(input logic [2:0] k, input logic inv);
      return inv ? ~k : k;
   endfunction

endpackage

// File: rtl/iso_char_rx_if.sv
// Line-side inputs and character-side outputs of the ISO 7816 receiver.
interface iso_char_rx_if #(
   parameter int unsigned ETU_WIDTH = iso7816_pkg::ETU_WIDTH_DEF
);
   logic                 enable;
   logic                 rxIn;
   logic [ETU_WIDTH-1:0] clocksPerEtu;
   logic                 inverseConvention;
   logic                 errorSignalEn;
   logic [7:0]           dataOut;
   logic                 dataValid;
   logic                 parityError;
   logic                 ioPullLow;
   logic                 busy;

   modport slave (
      input  enable, rxIn, clocksPerEtu, inverseConvention, errorSignalEn,
      output dataOut, dataValid, parityError, ioPullLow, busy
   );

   modport master (
      output enable, rxIn, clocksPerEtu, inverseConvention, errorSignalEn,
      input  dataOut, dataValid, parityError, ioPullLow, busy
   );
endinterface

// File: rtl/etu_timer.sv
// ETU counter: counts 0..limit_i and wraps; strobes at the mid-bit point and at wrap.
module etu_timer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic             half_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign half_o = (cnt_q == (limit_i >> 1));
   assign wrap_o = (cnt_q == limit_i);

   always_comb begin
      if (clear_i || wrap_o) cnt_d = '0;
      else                   cnt_d = cnt_q + WIDTH'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/iso_char_rx.sv
// ISO 7816 asynchronous character receiver with parity check and error signal.
module iso_char_rx
   import iso7816_pkg::*;
#(
   parameter int unsigned ETU_WIDTH = ETU_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         reset,
   iso_char_rx_if.slave bus
);

   rx_state_e            state_q, state_d;
   logic                 rx_prev_q;
   logic [ETU_WIDTH-1:0] etu_q, etu_d;
   logic [3:0]           idx_q, idx_d;
   logic [7:0]           shift_q, shift_d;
   logic [7:0]           data_q, data_d;
   logic                 bad_q, bad_d;
   logic                 done_q, done_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 pull_q, pull_d;
   logic                 busy_q;
   logic                 half, wrap;
   logic                 start_edge;
   logic                 rx_logic;

   etu_timer #(.WIDTH(ETU_WIDTH)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear_i (state_q == IDLE),
      .limit_i (etu_q),
      .half_o  (half),
      .wrap_o  (wrap)
   );

   assign start_edge = bus.enable && rx_prev_q && !bus.rxIn;
   assign rx_logic   = bus.rxIn ^ bus.inverseConvention;

   always_comb begin
      state_d = state_q;
      etu_d   = etu_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      bad_d   = bad_q;
      done_d  = done_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      pull_d  = pull_q;

      // idx_q counts whole etus since the start edge; bit n is sampled at idx n.
      if (wrap && idx_q != 4'hF) idx_d = idx_q + 4'd1;

      unique case (state_q)
         IDLE: begin
            idx_d = '0;
            if (start_edge) begin
               state_d = START;
               etu_d   = bus.clocksPerEtu;
            end
         end
         START: begin
            if (half) state_d = bus.rxIn ? IDLE : DATA;
         end
         DATA: begin
            if (half) begin
               shift_d[bit_pos(idx_q[2:0] - 3'd1, bus.inverseConvention)] = rx_logic;
               if (idx_q == 4'd8) state_d = PARITY;
            end
         end
         PARITY: begin
            // Parity is sampled first; the result is published one cycle later.
            if (done_q) begin
               data_d  = shift_q;
               valid_d = 1'b1;
               perr_d  = bad_q;
               done_d  = 1'b0;
               state_d = GUARD;
            end else if (half) begin
               bad_d  = (^shift_q) ^ rx_logic;
               done_d = 1'b1;
            end
         end
         GUARD: begin
            if (half) begin
               if (bad_q && bus.errorSignalEn) begin
                  state_d = ERRSIG;
                  pull_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         ERRSIG: begin
            if (half) begin
               state_d = IDLE;
               pull_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!bus.enable) begin
         state_d = IDLE;
         data_d  = data_q;
         valid_d = 1'b0;
         perr_d  = 1'b0;
         done_d  = 1'b0;
         pull_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rx_prev_q <= 1'b1;
         etu_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         bad_q     <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         pull_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_prev_q <= bus.rxIn;
         etu_q     <= etu_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         bad_q     <= bad_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         pull_q    <= pull_d;
         busy_q    <= (state_d != IDLE);
      end
   end

   assign bus.dataOut     = data_q;
   assign bus.dataValid   = valid_q;
   assign bus.parityError = perr_q;
   assign bus.ioPullLow   = pull_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_iso_char_rx.sv
// Directed self-checking bench for iso_char_rx: line frames with hand-computed results.
module tb_iso_char_rx;
   import iso7816_pkg::*;

   logic clk = 1'b0;
   logic reset;

   iso_char_rx_if #(.ETU_WIDTH(16)) bus ();

   iso_char_rx #(.ETU_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   int unsigned t0 = 0;
   int unsigned n_valid, n_perr, n_pull, valid_at, pull_at;
   logic [7:0]  got_data;

   // Line bit index 0 is the start bit, 1..8 data, 9 parity.
   localparam logic [9:0] L_3B_DIRECT  = 10'b1001110110;
   localparam logic [9:0] L_3F_INVERSE = 10'b1000000110;
   localparam logic [9:0] L_3B_BADPAR  = 10'b0001110110;
   localparam logic [9:0] L_A5_DIRECT  = 10'b0101001010;
   localparam logic [9:0] L_3F_DIRECT  = 10'b0001111110;

   always @(negedge clk) begin
      if (bus.dataValid) begin
         n_valid++;
         valid_at = cyc - t0;
         got_data = bus.dataOut;
      end
      if (bus.parityError) n_perr++;
      if (bus.ioPullLow) begin
         if (n_pull == 0) pull_at = cyc - t0;
         n_pull++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      n_valid  = 0;
      n_perr   = 0;
      n_pull   = 0;
      valid_at = 0;
      pull_at  = 0;
      got_data = 8'h00;
   endtask

   // action: 0 none, 1 drop enable at 5 etu, 2 reset at 5 etu, 3 clocksPerEtu -> 31 at 3 etu
   task automatic send_frame(input logic [9:0] line, input int unsigned etu, input int unsigned action);
      for (int unsigned i = 0; i < 10 * etu; i++) begin
         if (action == 3 && i == 3 * etu) bus.clocksPerEtu = 16'd31;
         if (action == 1 && i == 5 * etu) begin
            bus.enable = 1'b0;
            bus.rxIn   = 1'b1;
            idle(1);
            check("abort_en_busy", bus.busy, 1'b0);
            check("abort_en_pull", bus.ioPullLow, 1'b0);
            idle(3);
            bus.enable = 1'b1;
            return;
         end
         if (action == 2 && i == 5 * etu) begin
            reset    = 1'b1;
            bus.rxIn = 1'b1;
            #1;
            check("abort_rst_busy", bus.busy, 1'b0);
            check("abort_rst_data", bus.dataOut, 8'h00);
            idle(3);
            reset = 1'b0;
            return;
         end
         bus.rxIn = line[i / etu];
         idle(1);
         if (i == 0) begin
            t0 = cyc;
            check("busy_after_start", bus.busy, 1'b1);
         end
      end
      bus.rxIn = 1'b1;
   endtask

   initial begin
      reset                 = 1'b1;
      bus.enable            = 1'b0;
      bus.rxIn              = 1'b1;
      bus.clocksPerEtu      = 16'd371;
      bus.inverseConvention = 1'b0;
      bus.errorSignalEn     = 1'b0;
      clear_mon();
      idle(3);
      check("rst_data",  bus.dataOut, 8'h00);
      check("rst_valid", bus.dataValid, 1'b0);
      check("rst_perr",  bus.parityError, 1'b0);
      check("rst_pull",  bus.ioPullLow, 1'b0);
      check("rst_busy",  bus.busy, 1'b0);
      reset      = 1'b0;
      bus.enable = 1'b1;
      idle(10);

      // Direct 0x3B
      clear_mon();
      send_frame(L_3B_DIRECT, 372, 0);
      idle(800);
      check("d3b_nvalid", n_valid, 1);
      check("d3b_at",     valid_at, 3535);
      check("d3b_data",   got_data, 8'h3B);
      check("d3b_perr",   n_perr, 0);
      check("d3b_pull",   n_pull, 0);
      check("d3b_busy",   bus.busy, 1'b0);
      check("d3b_hold",   bus.dataOut, 8'h3B);

      // Inverse 0x3F
      clear_mon();
      bus.inverseConvention = 1'b1;
      send_frame(L_3F_INVERSE, 372, 0);
      idle(800);
      bus.inverseConvention = 1'b0;
      check("i3f_nvalid", n_valid, 1);
      check("i3f_at",     valid_at, 3535);
      check("i3f_data",   got_data, 8'h3F);
      check("i3f_perr",   n_perr, 0);

      // Bad parity with error signal
      clear_mon();
      bus.errorSignalEn = 1'b1;
      send_frame(L_3B_BADPAR, 372, 0);
      idle(800);
      bus.errorSignalEn = 1'b0;
      check("bp_nvalid",  n_valid, 1);
      check("bp_data",    got_data, 8'h3B);
      check("bp_perr",    n_perr, 1);
      check("bp_pull_at", pull_at, 3906);
      check("bp_pull_n",  n_pull, 372);
      check("bp_busy",    bus.busy, 1'b0);

      // Start-bit glitch: low for 100 cycles
      clear_mon();
      bus.rxIn = 1'b0;
      idle(1);
      t0 = cyc;
      for (int unsigned i = 1; i <= 186; i++) begin
         idle(1);
         if (i == 99)  bus.rxIn = 1'b1;
         if (i == 185) check("gl_busy_185", bus.busy, 1'b1);
         if (i == 186) check("gl_busy_186", bus.busy, 1'b0);
      end
      idle(400);
      check("gl_nvalid", n_valid, 0);
      clear_mon();
      send_frame(L_3B_DIRECT, 372, 0);
      idle(800);
      check("gl_next_nvalid", n_valid, 1);
      check("gl_next_data",   got_data, 8'h3B);

      // Enable dropped at 5 etu, then 0xA5
      clear_mon();
      send_frame(L_3B_DIRECT, 372, 1);
      idle(500);
      check("en_nvalid", n_valid, 0);
      check("en_hold",   bus.dataOut, 8'h3B);
      send_frame(L_A5_DIRECT, 372, 0);
      idle(800);
      check("en_a5_nvalid", n_valid, 1);
      check("en_a5_data",   got_data, 8'hA5);
      check("en_a5_perr",   n_perr, 0);

      // Reset at 5 etu, then 0xA5
      clear_mon();
      send_frame(L_3B_DIRECT, 372, 2);
      idle(500);
      check("rs_nvalid", n_valid, 0);
      send_frame(L_A5_DIRECT, 372, 0);
      idle(800);
      check("rs_a5_nvalid", n_valid, 1);
      check("rs_a5_at",     valid_at, 3535);
      check("rs_a5_data",   got_data, 8'hA5);

      // clocksPerEtu changed mid-frame
      clear_mon();
      send_frame(L_3B_DIRECT, 372, 3);
      idle(800);
      check("cp_old_nvalid", n_valid, 1);
      check("cp_old_at",     valid_at, 3535);
      check("cp_old_data",   got_data, 8'h3B);
      clear_mon();
      send_frame(L_3F_DIRECT, 32, 0);
      idle(100);
      check("cp_new_nvalid", n_valid, 1);
      check("cp_new_at",     valid_at, 305);
      check("cp_new_data",   got_data, 8'h3F);
      check("cp_new_perr",   n_perr, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
